// File: rtl/pipelined_cache_stage2_ctrl_if.sv
// Stage-2 cache controller bundle: stage-register inputs,
// physical-memory handshake, CPU response and array write enables.
interface pipelined_cache_stage2_ctrl_if #(
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5
);
    logic                       req_valid_i;
    logic                       hit_i;
    logic                       hit1_i;
    logic                       dirty_i;
    logic                       lru_i;
    logic                       mem_write_i;
    logic [ADDR_W-1:0]          address_i;
    logic [ADDR_W-OFFSET_W-1:0] victim_tag_line_i;
    logic [LINE_W-1:0]          mem_rdata_i;
    logic [LINE_W-1:0]          pmem_rdata_i;
    logic                       pmem_resp_i;

    logic                       pipe_load_o;
    logic                       resp_o;
    logic [LINE_W-1:0]          cpu_rdata_o;
    logic                       pmem_read_o;
    logic                       pmem_write_o;
    logic [ADDR_W-1:0]          pmem_address_o;
    logic [1:0]                 data_we_o;
    logic                       data_sel_o;
    logic [1:0]                 tag_we_o;
    logic [1:0]                 valid_we_o;
    logic [1:0]                 dirty_we_o;
    logic                       dirty_in_o;
    logic                       lru_we_o;
    logic                       lru_in_o;

    modport master (
        output req_valid_i, hit_i, hit1_i, dirty_i, lru_i,
        output mem_write_i, address_i, victim_tag_line_i,
        output mem_rdata_i, pmem_rdata_i, pmem_resp_i,
        input  pipe_load_o, resp_o, cpu_rdata_o,
        input  pmem_read_o, pmem_write_o, pmem_address_o,
        input  data_we_o, data_sel_o, tag_we_o, valid_we_o,
        input  dirty_we_o, dirty_in_o, lru_we_o, lru_in_o
    );

    modport slave (
        input  req_valid_i, hit_i, hit1_i, dirty_i, lru_i,
        input  mem_write_i, address_i, victim_tag_line_i,
        input  mem_rdata_i, pmem_rdata_i, pmem_resp_i,
        output pipe_load_o, resp_o, cpu_rdata_o,
        output pmem_read_o, pmem_write_o, pmem_address_o,
        output data_we_o, data_sel_o, tag_we_o, valid_we_o,
        output dirty_we_o, dirty_in_o, lru_we_o, lru_in_o
    );
endinterface

// File: rtl/pipelined_cache_stage2_ctrl.sv
// Stage-2 controller of the pipelined 2-way cache: hit response,
// miss writeback/fetch against physical memory, refill and replay.
module pipelined_cache_stage2_ctrl #(
    parameter int LINE_W   = 256,
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 5
) (
    input logic clk,
    input logic rst,
    pipelined_cache_stage2_ctrl_if.slave bus
);
    typedef enum logic [1:0] {CHECK, WB, FETCH, REPLAY} state_t;

    state_t            state, state_n;
    logic [LINE_W-1:0] line_buf;
    logic              way_r;
    logic              miss;

    logic              pipe_load, resp;
    logic [LINE_W-1:0] cpu_rdata;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [1:0]        data_we, tag_we, valid_we, dirty_we;
    logic              data_sel, dirty_in, lru_we, lru_in;

    assign miss = bus.req_valid_i & ~bus.hit_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CHECK;
            line_buf <= '0;
            way_r    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == CHECK && miss)
                way_r <= bus.lru_i;
            if (state == FETCH && bus.pmem_resp_i)
                line_buf <= bus.pmem_rdata_i;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            CHECK:   if (miss) state_n = bus.dirty_i ? WB : FETCH;
            WB:      if (bus.pmem_resp_i) state_n = FETCH;
            FETCH:   if (bus.pmem_resp_i) state_n = REPLAY;
            REPLAY:  state_n = CHECK;
            default: state_n = CHECK;
        endcase
    end

    always_comb begin
        pipe_load    = 1'b0;
        resp         = 1'b0;
        cpu_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        data_we      = 2'b00;
        data_sel     = 1'b0;
        tag_we       = 2'b00;
        valid_we     = 2'b00;
        dirty_we     = 2'b00;
        dirty_in     = 1'b0;
        lru_we       = 1'b0;
        lru_in       = 1'b0;
        unique case (state)
            CHECK: begin
                pipe_load = ~miss;
                if (bus.req_valid_i && bus.hit_i) begin
                    resp      = 1'b1;
                    cpu_rdata = bus.mem_rdata_i;
                    lru_we    = 1'b1;
                    lru_in    = ~bus.hit1_i;
                    if (bus.mem_write_i) begin
                        data_we[bus.hit1_i]  = 1'b1;
                        dirty_we[bus.hit1_i] = 1'b1;
                        dirty_in             = 1'b1;
                    end
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {bus.victim_tag_line_i, {OFFSET_W{1'b0}}};
            end
            FETCH: begin
                pmem_read    = 1'b1;
                pmem_address = {bus.address_i[ADDR_W-1:OFFSET_W],
                                {OFFSET_W{1'b0}}};
                // Refill writes the fresh line clean; a write request
                // re-dirties it during replay.
                if (bus.pmem_resp_i) begin
                    data_we[way_r]  = 1'b1;
                    data_sel        = 1'b1;
                    tag_we[way_r]   = 1'b1;
                    valid_we[way_r] = 1'b1;
                    dirty_we[way_r] = 1'b1;
                end
            end
            REPLAY: begin
                pipe_load = 1'b1;
                resp      = 1'b1;
                cpu_rdata = line_buf;
                lru_we    = 1'b1;
                lru_in    = ~way_r;
                if (bus.mem_write_i) begin
                    data_we[way_r]  = 1'b1;
                    dirty_we[way_r] = 1'b1;
                    dirty_in        = 1'b1;
                end
            end
            default: pipe_load = 1'b1;
        endcase
    end

    assign bus.pipe_load_o    = pipe_load;
    assign bus.resp_o         = resp;
    assign bus.cpu_rdata_o    = cpu_rdata;
    assign bus.pmem_read_o    = pmem_read;
    assign bus.pmem_write_o   = pmem_write;
    assign bus.pmem_address_o = pmem_address;
    assign bus.data_we_o      = data_we;
    assign bus.data_sel_o     = data_sel;
    assign bus.tag_we_o       = tag_we;
    assign bus.valid_we_o     = valid_we;
    assign bus.dirty_we_o     = dirty_we;
    assign bus.dirty_in_o     = dirty_in;
    assign bus.lru_we_o       = lru_we;
    assign bus.lru_in_o       = lru_in;
endmodule
